// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses ({rd,sel}), exception codes and
// the bit layout of a TLB entry as returned by the TLB array on TLBR.
package cp0_pkg;

    localparam logic [7:0] C0_INDEX    = 8'h00;  // rd 0,  sel 0
    localparam logic [7:0] C0_RANDOM   = 8'h08;  // rd 1
    localparam logic [7:0] C0_ENTRYLO0 = 8'h10;  // rd 2
    localparam logic [7:0] C0_ENTRYLO1 = 8'h18;  // rd 3
    localparam logic [7:0] C0_WIRED    = 8'h30;  // rd 6
    localparam logic [7:0] C0_BADVADDR = 8'h40;  // rd 8
    localparam logic [7:0] C0_COUNT    = 8'h48;  // rd 9
    localparam logic [7:0] C0_ENTRYHI  = 8'h50;  // rd 10
    localparam logic [7:0] C0_COMPARE  = 8'h58;  // rd 11
    localparam logic [7:0] C0_STATUS   = 8'h60;  // rd 12
    localparam logic [7:0] C0_CAUSE    = 8'h68;  // rd 13
    localparam logic [7:0] C0_EPC      = 8'h70;  // rd 14

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int TLB_ENTRY_W  = 78;
    localparam int TLB_V1_BIT   = 0;
    localparam int TLB_D1_BIT   = 1;
    localparam int TLB_C1_LSB   = 2;
    localparam int TLB_PFN1_LSB = 5;
    localparam int TLB_V0_BIT   = 25;
    localparam int TLB_D0_BIT   = 26;
    localparam int TLB_C0_LSB   = 27;
    localparam int TLB_PFN0_LSB = 30;
    localparam int TLB_G_BIT    = 50;
    localparam int TLB_ASID_LSB = 51;
    localparam int TLB_VPN2_LSB = 59;

    // Exceptions that report a faulting address (TLB + address error).
    function automatic logic exc_has_badvaddr(input logic [4:0] code);
        return (code >= EXC_MOD) && (code <= EXC_ADES);
    endfunction

    // TLB exceptions additionally capture the faulting VPN2 into EntryHi.
    function automatic logic exc_is_tlb(input logic [4:0] code);
        return (code >= EXC_MOD) && (code <= EXC_TLBS);
    endfunction

    // Builds the 26 live EntryLo bits {PFN,C,D,V,G} for the even/odd page.
    function automatic logic [25:0] tlb_entrylo(input logic [TLB_ENTRY_W-1:0] e,
                                                input logic odd);
        if (odd)
            return {e[TLB_PFN1_LSB +: 20], e[TLB_C1_LSB +: 3], e[TLB_D1_BIT],
                    e[TLB_V1_BIT], e[TLB_G_BIT]};
        return {e[TLB_PFN0_LSB +: 20], e[TLB_C0_LSB +: 3], e[TLB_D0_BIT],
                e[TLB_V0_BIT], e[TLB_G_BIT]};
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: Count advances once every CNT_DIV clocks and
// TI latches one cycle after Count matches a nonzero Compare.
module cp0_timer #(
    parameter int CNT_DIV = 2
) (
    input  logic        cp0_clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);
    localparam int DIV_W = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CNT_DIV - 1);

    logic [DIV_W-1:0] div_reg;
    logic [31:0]      count_reg;
    logic [31:0]      compare_reg;
    logic             ti_reg;
    logic             tick;

    assign tick = (div_reg == DIV_LAST);

    always_ff @(posedge cp0_clk or posedge reset) begin
        if (reset) begin
            div_reg   <= '0;
            count_reg <= '0;
        end else if (count_we) begin
            div_reg   <= '0;
            count_reg <= wdata;
        end else begin
            div_reg   <= tick ? '0 : div_reg + DIV_W'(1);
            if (tick)
                count_reg <= count_reg + 32'd1;
        end
    end

    // A Compare write acknowledges the interrupt even if a match is pending.
    always_ff @(posedge cp0_clk or posedge reset) begin
        if (reset) begin
            compare_reg <= '0;
            ti_reg      <= 1'b0;
        end else if (compare_we) begin
            compare_reg <= wdata;
            ti_reg      <= 1'b0;
        end else if ((count_reg == compare_reg) && (compare_reg != 32'd0)) begin
            ti_reg      <= 1'b1;
        end
    end

    assign count   = count_reg;
    assign compare = compare_reg;
    assign ti      = ti_reg;

endmodule

// File: rtl/cp0_tlbctl.sv
// CP0 register file for a TLB-based MIPS core: exception state, interrupts,
// timer and the Index/Random/Wired/EntryHi/EntryLo TLB interface registers.
module cp0_tlbctl
    import cp0_pkg::*;
#(
    parameter int  TLBNUM  = 16,
    parameter int  CNT_DIV = 2,
    parameter int  HW_INT  = 6,
    localparam int IDX_W   = $clog2(TLBNUM)
) (
    input  logic                   cp0_clk,
    input  logic                   reset,
    input  logic                   mtc0_we,
    input  logic [7:0]             c0_addr,
    input  logic [31:0]            c0_wdata,
    output logic [31:0]            c0_rdata,
    input  logic                   wb_ex,
    input  logic [4:0]             wb_excode,
    input  logic                   wb_bd,
    input  logic [31:0]            wb_pc,
    input  logic [31:0]            wb_badvaddr,
    input  logic                   eret,
    input  logic [HW_INT-1:0]      hw_int,
    output logic                   has_int,
    output logic [31:0]            epc_out,
    input  logic                   tlbr,
    input  logic                   tlbp,
    input  logic                   tlbwr,
    input  logic                   tlbp_found,
    input  logic [IDX_W-1:0]       tlbp_idx,
    input  logic [TLB_ENTRY_W-1:0] tlb_rdata,
    output logic [31:0]            cp0_index,
    output logic [31:0]            cp0_entryhi,
    output logic [31:0]            cp0_entrylo0,
    output logic [31:0]            cp0_entrylo1,
    output logic [IDX_W-1:0]       random_idx
);
    localparam logic [IDX_W-1:0] RANDOM_TOP = IDX_W'(TLBNUM - 1);

    logic             exl_reg, ie_reg, bd_reg, p_reg;
    logic [7:0]       im_reg;
    logic [1:0]       ip_sw_reg;
    logic [5:0]       ip_hw_reg;
    logic [5:0]       ip_hw_next;
    logic [5:0]       hw_lines;
    logic [4:0]       excode_reg;
    logic [31:0]      epc_reg, badvaddr_reg;
    logic [IDX_W-1:0] index_reg, wired_reg, random_reg;
    logic [18:0]      vpn2_reg;
    logic [7:0]       asid_reg;
    logic [25:0]      lo0_reg, lo1_reg;
    logic [31:0]      count, compare;
    logic             ti;
    logic [31:0]      status_view, cause_view;

    // An exception retiring in the same slot squashes the MTC0 completely.
    logic mtc0_ok;
    logic wr_index, wr_lo0, wr_lo1, wr_wired, wr_count, wr_hi;
    logic wr_compare, wr_status, wr_cause, wr_epc;

    assign mtc0_ok    = mtc0_we & ~wb_ex;
    assign wr_index   = mtc0_ok && (c0_addr == C0_INDEX);
    assign wr_lo0     = mtc0_ok && (c0_addr == C0_ENTRYLO0);
    assign wr_lo1     = mtc0_ok && (c0_addr == C0_ENTRYLO1);
    assign wr_wired   = mtc0_ok && (c0_addr == C0_WIRED);
    assign wr_count   = mtc0_ok && (c0_addr == C0_COUNT);
    assign wr_hi      = mtc0_ok && (c0_addr == C0_ENTRYHI);
    assign wr_compare = mtc0_ok && (c0_addr == C0_COMPARE);
    assign wr_status  = mtc0_ok && (c0_addr == C0_STATUS);
    assign wr_cause   = mtc0_ok && (c0_addr == C0_CAUSE);
    assign wr_epc     = mtc0_ok && (c0_addr == C0_EPC);

    cp0_timer #(.CNT_DIV(CNT_DIV)) u_timer (
        .cp0_clk    (cp0_clk),
        .reset      (reset),
        .count_we   (wr_count),
        .compare_we (wr_compare),
        .wdata      (c0_wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    // Unimplemented interrupt lines are tied low so IP reads back 0.
    genvar gi;
    for (gi = 0; gi < 6; gi++) begin : g_hw_line
        if (gi < HW_INT) begin : g_present
            assign hw_lines[gi] = hw_int[gi];
        end else begin : g_absent
            assign hw_lines[gi] = 1'b0;
        end
    end
    assign ip_hw_next = {hw_lines[5] | ti, hw_lines[4:0]};

    always_ff @(posedge cp0_clk or posedge reset) begin
        if (reset) begin
            ip_hw_reg <= '0;
            ip_sw_reg <= '0;
        end else begin
            ip_hw_reg <= ip_hw_next;
            if (wr_cause)
                ip_sw_reg <= c0_wdata[9:8];
        end
    end

    always_ff @(posedge cp0_clk or posedge reset) begin
        if (reset) begin
            exl_reg <= 1'b0;
            ie_reg  <= 1'b0;
            im_reg  <= '0;
        end else begin
            if (wb_ex)
                exl_reg <= 1'b1;
            else if (eret)
                exl_reg <= 1'b0;
            else if (wr_status)
                exl_reg <= c0_wdata[1];
            if (wr_status) begin
                ie_reg <= c0_wdata[0];
                im_reg <= c0_wdata[15:8];
            end
        end
    end

    // Nested exceptions (EXL already set) keep the original EPC/BD.
    always_ff @(posedge cp0_clk or posedge reset) begin
        if (reset) begin
            bd_reg       <= 1'b0;
            excode_reg   <= EXC_INT;
            epc_reg      <= '0;
            badvaddr_reg <= '0;
        end else if (wb_ex) begin
            excode_reg <= wb_excode;
            if (!exl_reg) begin
                bd_reg  <= wb_bd;
                epc_reg <= wb_bd ? (wb_pc - 32'd4) : wb_pc;
            end
            if (exc_has_badvaddr(wb_excode))
                badvaddr_reg <= wb_badvaddr;
        end else if (wr_epc) begin
            epc_reg <= c0_wdata;
        end
    end

    always_ff @(posedge cp0_clk or posedge reset) begin
        if (reset) begin
            p_reg     <= 1'b0;
            index_reg <= '0;
        end else begin
            if (tlbp)
                p_reg <= ~tlbp_found;
            if (wr_index)
                index_reg <= c0_wdata[IDX_W-1:0];
            else if (tlbp && tlbp_found)
                index_reg <= tlbp_idx;
        end
    end

    // Random walks down to Wired and wraps to the top; Wired >= top pins it.
    always_ff @(posedge cp0_clk or posedge reset) begin
        if (reset) begin
            wired_reg  <= '0;
            random_reg <= RANDOM_TOP;
        end else if (wr_wired) begin
            wired_reg  <= c0_wdata[IDX_W-1:0];
            random_reg <= RANDOM_TOP;
        end else if (tlbwr) begin
            random_reg <= (random_reg <= wired_reg) ? RANDOM_TOP
                                                    : random_reg - IDX_W'(1);
        end
    end

    always_ff @(posedge cp0_clk or posedge reset) begin
        if (reset) begin
            vpn2_reg <= '0;
            asid_reg <= '0;
            lo0_reg  <= '0;
            lo1_reg  <= '0;
        end else begin
            if (wr_hi) begin
                vpn2_reg <= c0_wdata[31:13];
                asid_reg <= c0_wdata[7:0];
            end else if (wb_ex && exc_is_tlb(wb_excode)) begin
                vpn2_reg <= wb_badvaddr[31:13];
            end else if (tlbr) begin
                vpn2_reg <= tlb_rdata[TLB_VPN2_LSB +: 19];
                asid_reg <= tlb_rdata[TLB_ASID_LSB +: 8];
            end
            if (wr_lo0)
                lo0_reg <= c0_wdata[25:0];
            else if (tlbr)
                lo0_reg <= tlb_entrylo(tlb_rdata, 1'b0);
            if (wr_lo1)
                lo1_reg <= c0_wdata[25:0];
            else if (tlbr)
                lo1_reg <= tlb_entrylo(tlb_rdata, 1'b1);
        end
    end

    assign status_view  = {9'b0, 1'b1, 6'b0, im_reg, 6'b0, exl_reg, ie_reg};
    assign cause_view   = {bd_reg, ti, 14'b0, ip_hw_reg, ip_sw_reg, 1'b0, excode_reg, 2'b0};
    assign cp0_index    = {p_reg, 31'(index_reg)};
    assign cp0_entryhi  = {vpn2_reg, 5'b0, asid_reg};
    assign cp0_entrylo0 = {6'b0, lo0_reg};
    assign cp0_entrylo1 = {6'b0, lo1_reg};
    assign random_idx   = random_reg;
    assign epc_out      = epc_reg;
    assign has_int      = (|({ip_hw_reg, ip_sw_reg} & im_reg)) & ie_reg & ~exl_reg;

    always_comb begin
        c0_rdata = 32'd0;
        case (c0_addr)
            C0_INDEX:    c0_rdata = cp0_index;
            C0_RANDOM:   c0_rdata = 32'(random_reg);
            C0_ENTRYLO0: c0_rdata = cp0_entrylo0;
            C0_ENTRYLO1: c0_rdata = cp0_entrylo1;
            C0_WIRED:    c0_rdata = 32'(wired_reg);
            C0_BADVADDR: c0_rdata = badvaddr_reg;
            C0_COUNT:    c0_rdata = count;
            C0_ENTRYHI:  c0_rdata = cp0_entryhi;
            C0_COMPARE:  c0_rdata = compare;
            C0_STATUS:   c0_rdata = status_view;
            C0_CAUSE:    c0_rdata = cause_view;
            C0_EPC:      c0_rdata = epc_reg;
            default:     c0_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_tlbctl.sv
// Directed bench for cp0_tlbctl (TLBNUM=16, CNT_DIV=2, HW_INT=6).
module tb_cp0_tlbctl;
    import cp0_pkg::*;

    logic        cp0_clk, reset;
    logic        mtc0_we;
    logic [7:0]  c0_addr;
    logic [31:0] c0_wdata, c0_rdata;
    logic        wb_ex, wb_bd, eret;
    logic [4:0]  wb_excode;
    logic [31:0] wb_pc, wb_badvaddr;
    logic [5:0]  hw_int;
    logic        has_int;
    logic [31:0] epc_out;
    logic        tlbr, tlbp, tlbwr, tlbp_found;
    logic [3:0]  tlbp_idx;
    logic [77:0] tlb_rdata;
    logic [31:0] cp0_index, cp0_entryhi, cp0_entrylo0, cp0_entrylo1;
    logic [3:0]  random_idx;

    int n_assert = 0;
    int n_fail   = 0;

    cp0_tlbctl #(.TLBNUM(16), .CNT_DIV(2), .HW_INT(6)) dut (
        .cp0_clk(cp0_clk), .reset(reset), .mtc0_we(mtc0_we), .c0_addr(c0_addr),
        .c0_wdata(c0_wdata), .c0_rdata(c0_rdata), .wb_ex(wb_ex),
        .wb_excode(wb_excode), .wb_bd(wb_bd), .wb_pc(wb_pc),
        .wb_badvaddr(wb_badvaddr), .eret(eret), .hw_int(hw_int),
        .has_int(has_int), .epc_out(epc_out), .tlbr(tlbr), .tlbp(tlbp),
        .tlbwr(tlbwr), .tlbp_found(tlbp_found), .tlbp_idx(tlbp_idx),
        .tlb_rdata(tlb_rdata), .cp0_index(cp0_index), .cp0_entryhi(cp0_entryhi),
        .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1),
        .random_idx(random_idx)
    );

    initial cp0_clk = 1'b0;
    always #5 cp0_clk = ~cp0_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge cp0_clk);
        #1;
    endtask

    task automatic mtc0(input logic [7:0] addr, input logic [31:0] data);
        mtc0_we  = 1'b1;
        c0_addr  = addr;
        c0_wdata = data;
        tick();
        mtc0_we  = 1'b0;
    endtask

    task automatic rdc(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        c0_addr = addr;
        #1;
        check(tag, c0_rdata, exp);
    endtask

    task automatic exc(input logic [4:0] code, input logic bd, input logic [31:0] pc,
                       input logic [31:0] bad);
        wb_ex = 1'b1; wb_excode = code; wb_bd = bd; wb_pc = pc; wb_badvaddr = bad;
        tick();
        wb_ex = 1'b0;
    endtask

    initial begin
        reset = 1'b1; mtc0_we = 1'b0; c0_addr = 8'h00; c0_wdata = '0;
        wb_ex = 1'b0; wb_excode = '0; wb_bd = 1'b0; wb_pc = '0; wb_badvaddr = '0;
        eret = 1'b0; hw_int = '0; tlbr = 1'b0; tlbp = 1'b0; tlbwr = 1'b0;
        tlbp_found = 1'b0; tlbp_idx = '0; tlb_rdata = '0;
        tick(); tick();

        // Reset state
        check("rst_has_int", 32'(has_int), 32'd0);
        check("rst_random", 32'(random_idx), 32'd15);
        rdc("rst_status", C0_STATUS, 32'h0040_0000);
        rdc("rst_cause", C0_CAUSE, 32'h0);
        rdc("rst_count", C0_COUNT, 32'h0);
        check("rst_epc", epc_out, 32'h0);
        check("rst_entryhi", cp0_entryhi, 32'h0);
        rdc("unmapped_read", 8'h38, 32'h0);
        reset = 1'b0;
        tick();

        // Timer: Count=5, Compare=8, divide by 2
        mtc0(C0_COUNT, 32'd5);
        mtc0(C0_COMPARE, 32'd8);
        rdc("count_loaded", C0_COUNT, 32'd5);
        repeat (5) tick();
        rdc("count_at_8", C0_COUNT, 32'd8);
        rdc("ti_not_yet", C0_CAUSE, 32'h0);
        tick();
        rdc("ti_set", C0_CAUSE, 32'h4000_0000);
        tick();
        rdc("ti_to_ip7", C0_CAUSE, 32'h4000_8000);
        mtc0(C0_COMPARE, 32'h20);
        rdc("ti_cleared", C0_CAUSE, 32'h0000_8000);
        tick();
        rdc("ip7_cleared", C0_CAUSE, 32'h0);
        mtc0(C0_COMPARE, 32'h0);

        // Hardware interrupt 5 with IM7/IE
        mtc0(C0_STATUS, 32'h0000_8001);
        rdc("status_im7_ie", C0_STATUS, 32'h0040_8001);
        check("no_int_yet", 32'(has_int), 32'd0);
        hw_int = 6'b100000;
        tick();
        hw_int = 6'b000000;
        check("hw5_pulse_int", 32'(has_int), 32'd1);
        rdc("hw5_pulse_ip", C0_CAUSE, 32'h0000_8000);
        tick();
        check("hw5_pulse_gone", 32'(has_int), 32'd0);
        hw_int = 6'b100000;
        tick();
        check("hw5_level_int", 32'(has_int), 32'd1);
        mtc0(C0_STATUS, 32'h0000_8003);
        check("exl_masks_int", 32'(has_int), 32'd0);
        rdc("status_exl", C0_STATUS, 32'h0040_8003);
        hw_int = 6'b000000;
        mtc0(C0_STATUS, 32'h0000_0101);
        check("hw_low_no_int", 32'(has_int), 32'd0);
        mtc0(C0_CAUSE, 32'hFFFF_FFFF);
        rdc("sw_ip_write", C0_CAUSE, 32'h0000_0300);
        check("sw_int", 32'(has_int), 32'd1);
        mtc0(C0_CAUSE, 32'h0);
        check("sw_int_clr", 32'(has_int), 32'd0);
        mtc0(C0_STATUS, 32'h0);

        // Exception in delay slot with TLB refill code
        mtc0(C0_ENTRYHI, 32'hFFFF_FFAA);
        check("entryhi_mask", cp0_entryhi, 32'hFFFF_E0AA);
        exc(EXC_TLBL, 1'b1, 32'hBFC0_0104, 32'h1234_6789);
        check("epc_bd", epc_out, 32'hBFC0_0100);
        rdc("cause_bd", C0_CAUSE, 32'h8000_0008);
        rdc("badvaddr", C0_BADVADDR, 32'h1234_6789);
        check("entryhi_vpn2", cp0_entryhi, 32'h1234_60AA);
        rdc("status_exl_set", C0_STATUS, 32'h0040_0002);
        exc(EXC_ADEL, 1'b0, 32'h8000_0000, 32'h0000_0ABC);
        check("epc_held", epc_out, 32'hBFC0_0100);
        rdc("cause_nested", C0_CAUSE, 32'h8000_0010);
        rdc("badvaddr_adel", C0_BADVADDR, 32'h0000_0ABC);
        check("entryhi_held", cp0_entryhi, 32'h1234_60AA);

        // eret, then wb_ex + eret + MTC0 Status together
        eret = 1'b1; tick(); eret = 1'b0;
        rdc("eret_clears", C0_STATUS, 32'h0040_0000);
        mtc0(C0_STATUS, 32'h0000_FF01);
        rdc("status_ff01", C0_STATUS, 32'h0040_FF01);
        eret = 1'b1; mtc0_we = 1'b1; c0_addr = C0_STATUS; c0_wdata = 32'h0;
        exc(EXC_SYS, 1'b0, 32'h0000_0100, 32'h0000_DEAD);
        eret = 1'b0; mtc0_we = 1'b0;
        rdc("ex_wins", C0_STATUS, 32'h0040_FF03);
        rdc("cause_sys", C0_CAUSE, 32'h0000_0020);
        check("epc_sys", epc_out, 32'h0000_0100);
        rdc("badvaddr_keep", C0_BADVADDR, 32'h0000_0ABC);
        check("int_off_exl", 32'(has_int), 32'd0);
        eret = 1'b1; tick(); eret = 1'b0;
        mtc0(C0_STATUS, 32'h0);

        // Random / Wired
        mtc0(C0_WIRED, 32'd3);
        rdc("wired_rd", C0_WIRED, 32'd3);
        rdc("random_rd", C0_RANDOM, 32'd15);
        for (int i = 0; i < 13; i++) begin
            check($sformatf("random_walk%0d", i), 32'(random_idx), 32'(15 - i));
            tlbwr = 1'b1; tick(); tlbwr = 1'b0;
        end
        check("random_wrap", 32'(random_idx), 32'd15);
        tlbwr = 1'b1; tick(); tlbwr = 1'b0;
        check("random_after_wrap", 32'(random_idx), 32'd14);
        mtc0(C0_WIRED, 32'd15);
        check("random_wired_reset", 32'(random_idx), 32'd15);
        tlbwr = 1'b1; tick(); tick(); tlbwr = 1'b0;
        check("random_pinned", 32'(random_idx), 32'd15);

        // Index / TLBP
        mtc0(C0_INDEX, 32'h8000_0007);
        check("index_p_ro", cp0_index, 32'h0000_0007);
        tlbp = 1'b1; tlbp_found = 1'b0; tlbp_idx = 4'd5; tick(); tlbp = 1'b0;
        check("tlbp_miss", cp0_index, 32'h8000_0007);
        tlbp = 1'b1; tlbp_found = 1'b1; tlbp_idx = 4'd9; tick(); tlbp = 1'b0;
        check("tlbp_hit", cp0_index, 32'h0000_0009);

        // TLBR, then TLBR racing an EntryLo0 write
        tlb_rdata = {19'h2AAAA, 8'h3C, 1'b1, 20'h12345, 3'd3, 1'b1, 1'b1,
                     20'hABCDE, 3'd2, 1'b0, 1'b1};
        tlbr = 1'b1; tick(); tlbr = 1'b0;
        check("tlbr_hi", cp0_entryhi, 32'h5555_403C);
        check("tlbr_lo0", cp0_entrylo0, 32'h0048_D15F);
        check("tlbr_lo1", cp0_entrylo1, 32'h02AF_3793);
        tlb_rdata = '0;
        tlbr = 1'b1;
        mtc0(C0_ENTRYLO0, 32'hFFFF_FFFF);
        tlbr = 1'b0;
        check("mtc0_beats_tlbr", cp0_entrylo0, 32'h03FF_FFFF);
        check("tlbr_lo1_zero", cp0_entrylo1, 32'h0);
        check("tlbr_hi_zero", cp0_entryhi, 32'h0);

        // Count wrap
        mtc0(C0_COUNT, 32'hFFFF_FFFF);
        tick();
        rdc("count_max", C0_COUNT, 32'hFFFF_FFFF);
        tick();
        rdc("count_wrap", C0_COUNT, 32'h0);

        // Reset in the middle of an active interrupt
        mtc0(C0_STATUS, 32'h0000_FF01);
        hw_int = 6'b111111;
        tick();
        check("pre_reset_int", 32'(has_int), 32'd1);
        reset = 1'b1;
        #1;
        check("reset_int_drop", 32'(has_int), 32'd0);
        tick();
        check("reset_hold_int", 32'(has_int), 32'd0);
        check("reset_random", 32'(random_idx), 32'd15);
        rdc("reset_status", C0_STATUS, 32'h0040_0000);
        rdc("reset_cause", C0_CAUSE, 32'h0);
        reset = 1'b0;
        hw_int = 6'b000000;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
